// File: rtl/sdf_fft_frame_ctrl.sv
// sdf_fft_frame_ctrl: frame sequencer in front of an R2SDF FFT pipeline.
// Accepts a valid/ready complex sample stream and drives the pipeline
// enable/data. Short frames are padded with zeros, and a zero flush is
// injected when the stream stops at a frame boundary so the last frame
// drains. Pipeline result beats are tagged with frame first/last/index,
// and beats that carry no pending frame (flush garbage) are dropped.
// Optional feature macro: SDF_BITREV_EN (m_idx reports the bit-reversed
// output counter, i.e. the natural-order frequency bin).
module sdf_fft_frame_ctrl #(
    parameter int FFT_STAGE = 3,
    parameter int DATA_W    = 16,
    parameter int FLUSH_LEN = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [DATA_W-1:0]    s_re,
    input  logic signed [DATA_W-1:0]    s_im,
    input  logic                        s_last,
    output logic                        dp_en,
    output logic signed [DATA_W-1:0]    dp_re,
    output logic signed [DATA_W-1:0]    dp_im,
    input  logic                        dp_do_en,
    output logic                        m_valid,
    output logic                        m_first,
    output logic                        m_last,
    output logic [FFT_STAGE-1:0]        m_idx,
    output logic                        frame_err,
    output logic                        busy
);

    localparam int                    N        = 1 << FFT_STAGE;
    localparam int                    PEND_W   = FFT_STAGE + 1;
    localparam int                    FL_W     = $clog2(FLUSH_LEN + 1);
    localparam logic [FFT_STAGE-1:0]  CNT_LAST = FFT_STAGE'(N - 1);
    localparam logic [PEND_W-1:0]     PEND_MAX = '1;
    localparam logic [FL_W-1:0]       FL_LAST  = FL_W'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAD   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [FFT_STAGE-1:0]       in_cnt;
    logic [FFT_STAGE-1:0]       out_cnt;
    logic [PEND_W-1:0]          pend;
    logic [FL_W-1:0]            fl_cnt;

    logic                       can_take;
    logic                       accept;
    logic                       short_last;
    logic                       zero_beat;
    logic                       frame_done;
    logic                       issue;
    logic                       flush_end;
    logic                       out_take;
    logic                       out_wrap;

    logic                       vld_p0;
    logic signed [DATA_W-1:0]   re_p0;
    logic signed [DATA_W-1:0]   im_p0;

    // Frame counter: one increment per pending frame, one decrement per
    // completed output frame; holds at the top rather than wrapping.
    function automatic logic [PEND_W-1:0] pend_update(
        input logic [PEND_W-1:0] cur,
        input logic              inc,
        input logic              dec
    );
        logic [PEND_W-1:0] nxt;
        nxt = cur;
        if (inc && !dec) begin
            nxt = (cur == PEND_MAX) ? cur : cur + 1'b1;
        end else if (dec && !inc) begin
            nxt = cur - 1'b1;
        end
        return nxt;
    endfunction

    // Output index mapping: raw beat counter, or its bit reversal so the
    // index names the frequency bin of the bit-reversed SDF output order.
    function automatic logic [FFT_STAGE-1:0] idx_map(input logic [FFT_STAGE-1:0] cnt);
        logic [FFT_STAGE-1:0] r;
`ifdef SDF_BITREV_EN
        for (int i = 0; i < FFT_STAGE; i++) begin
            r[i] = cnt[FFT_STAGE-1-i];
        end
`else
        r = cnt;
`endif
        return r;
    endfunction

    // Handshake is open only in IDLE/RUN and never while reset is held.
    assign can_take   = (state == IDLE) || (state == RUN);
    assign s_ready    = rstn && can_take;
    assign accept     = s_valid && s_ready;
    assign short_last = accept && s_last && (in_cnt != CNT_LAST);
    assign issue      = accept || zero_beat;
    assign flush_end  = (state == FLUSH) && (fl_cnt == FL_LAST);

    // A result beat is only meaningful while a frame is pending.
    assign out_take   = dp_do_en && (pend != '0);
    assign out_wrap   = out_take && (out_cnt == CNT_LAST);

    assign busy       = (state != IDLE) || (pend != '0);

    assign dp_en      = vld_p0;
    assign dp_re      = re_p0;
    assign dp_im      = im_p0;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, zero-beat injection and frame-completion detect.
    always_comb begin
        state_nxt  = state;
        zero_beat  = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    frame_done = (in_cnt == CNT_LAST);
                    state_nxt  = short_last ? PAD : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    frame_done = (in_cnt == CNT_LAST);
                    if (short_last) begin
                        state_nxt = PAD;
                    end
                end else if (in_cnt == '0) begin
                    // Stream paused exactly on a frame boundary: drain.
                    state_nxt = FLUSH;
                end
            end
            PAD: begin
                zero_beat = 1'b1;
                if (in_cnt == CNT_LAST) begin
                    frame_done = 1'b1;
                    state_nxt  = RUN;
                end
            end
            FLUSH: begin
                zero_beat = 1'b1;
                if (fl_cnt == FL_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Input beat position within the frame and flush length counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            in_cnt <= '0;
            fl_cnt <= '0;
        end else begin
            // Leaving FLUSH always re-aligns to a frame start, even when
            // FLUSH_LEN is not a multiple of N.
            if (flush_end) begin
                in_cnt <= '0;
            end else if (issue) begin
                in_cnt <= in_cnt + 1'b1;
            end
            if (state == FLUSH) begin
                fl_cnt <= flush_end ? '0 : fl_cnt + 1'b1;
            end else begin
                fl_cnt <= '0;
            end
        end
    end

    // Pipeline input stage: accepted sample or injected zero, one cycle late.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p0 <= 1'b0;
            re_p0  <= '0;
            im_p0  <= '0;
        end else begin
            vld_p0 <= issue;
            if (accept) begin
                re_p0 <= s_re;
                im_p0 <= s_im;
            end else if (zero_beat) begin
                re_p0 <= '0;
                im_p0 <= '0;
            end
        end
    end

    // Short-frame error pulse, one cycle after the offending s_last.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= short_last;
        end
    end

    // Pending-frame count: completed input frames not yet fully output.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend <= '0;
        end else begin
            pend <= pend_update(pend, frame_done, out_wrap);
        end
    end

    // Output beat counter; held while no frame is pending.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_cnt <= '0;
        end else if (out_take) begin
            out_cnt <= out_cnt + 1'b1;
        end
    end

    // Output tag stage: qualified valid plus first/last/index tags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_valid <= 1'b0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
            m_idx   <= '0;
        end else begin
            m_valid <= out_take;
            m_first <= out_take && (out_cnt == '0);
            m_last  <= out_wrap;
            if (out_take) begin
                m_idx <= idx_map(out_cnt);
            end
        end
    end

endmodule

// File: tb/tb_sdf_fft_frame_ctrl.sv
// Self-checking bench for sdf_fft_frame_ctrl. A stand-in pipeline returns
// one result beat per input beat once primed with N-1 beats; a reference
// model predicts the pipeline input stream and the tagged output stream
// from frame lengths alone.
module tb_sdf_fft_frame_ctrl;

    localparam int FFT_STAGE = 3;
    localparam int DATA_W    = 16;
    localparam int FLUSH_LEN = 8;
    localparam int N         = 1 << FFT_STAGE;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   s_valid;
    logic                   s_ready;
    logic [DATA_W-1:0]      s_re;
    logic [DATA_W-1:0]      s_im;
    logic                   s_last;
    logic                   dp_en;
    logic [DATA_W-1:0]      dp_re;
    logic [DATA_W-1:0]      dp_im;
    logic                   dp_do_en = 1'b0;
    logic                   m_valid;
    logic                   m_first;
    logic                   m_last;
    logic [FFT_STAGE-1:0]   m_idx;
    logic                   frame_err;
    logic                   busy;

    int n_checks = 0;
    int n_fail   = 0;

    int  en_beats = 0;
    bit  extra_do = 1'b0;
    int  err_cnt  = 0;
    logic [2*DATA_W-1:0]    dp_q[$];
    logic [FFT_STAGE+1:0]   m_q[$];

    sdf_fft_frame_ctrl #(
        .FFT_STAGE (FFT_STAGE),
        .DATA_W    (DATA_W),
        .FLUSH_LEN (FLUSH_LEN)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_re      (s_re),
        .s_im      (s_im),
        .s_last    (s_last),
        .dp_en     (dp_en),
        .dp_re     (dp_re),
        .dp_im     (dp_im),
        .dp_do_en  (dp_do_en),
        .m_valid   (m_valid),
        .m_first   (m_first),
        .m_last    (m_last),
        .m_idx     (m_idx),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Pipeline stand-in and stream recorder, evaluated mid-cycle.
    always @(negedge clk) begin
        dp_do_en = (dp_en && (en_beats >= N - 1)) || extra_do;
        if (dp_en) begin
            en_beats++;
            dp_q.push_back({dp_re, dp_im});
        end
        if (m_valid) m_q.push_back({m_first, m_last, m_idx});
        if (frame_err) err_cnt++;
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    // Expected tag of the k-th output beat: {first, last, index}.
    function automatic logic [FFT_STAGE+1:0] exp_tag(input int k);
        int pos;
        int bin;
        pos = k % N;
        bin = pos;
`ifdef SDF_BITREV_EN
        bin = 0;
        for (int b = 0; b < FFT_STAGE; b++) begin
            if (((pos >> b) & 1) == 1) bin += 1 << (FFT_STAGE - 1 - b);
        end
`endif
        return {pos == 0, pos == N - 1, FFT_STAGE'(bin)};
    endfunction

    // Offer one sample (called at a negedge); returns at the negedge after
    // the accepting edge.
    task automatic send(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im,
                        input logic last, output bit ok);
        int g;
        g = 0;
        s_valid = 1'b1;
        s_re    = re;
        s_im    = im;
        s_last  = last;
        while (!s_ready && g < 64) begin
            @(negedge clk);
            g++;
        end
        ok = s_ready;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int g;
        g = 0;
        while (busy && g < 300) begin
            @(negedge clk);
            g++;
        end
        ok = !busy;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        s_valid = 1'b1;
        s_re    = 16'h1234;
        s_im    = 16'h0042;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low: got %b want 0", s_ready);
        end
        s_valid = 1'b0;
        rstn    = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_idle: got %b want 1", s_ready);
        end
        n_checks++;
        if ({dp_en, m_valid, m_first, m_last, frame_err, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {dp_en, m_valid, m_first, m_last, frame_err, busy});
        end
        n_checks++;
        if ({dp_re, dp_im, m_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got re=%h im=%h idx=%0d want 0", dp_re, dp_im, m_idx);
        end
    endtask

    task automatic test_single_frame();
        logic [2*DATA_W-1:0] exp_dp[$];
        logic [DATA_W-1:0]   re;
        logic [DATA_W-1:0]   im;
        bit ok;
        int lowc;
        int g;
        int bad;
        int e0;
        dp_q.delete();
        m_q.delete();
        e0 = err_cnt;
        for (int i = 1; i <= N; i++) begin
            re = DATA_W'(i);
            im = DATA_W'($urandom);
            send(re, im, i == N, ok);
            exp_dp.push_back({re, im});
            n_checks++;
            if ({ok, dp_en, dp_re, dp_im} !== {1'b1, 1'b1, re, im}) begin
                n_fail++;
                $display("FAIL single_dp_delay[%0d]: got ok=%b en=%b re=%h im=%h want 1 1 %h %h",
                         i, ok, dp_en, dp_re, dp_im, re, im);
            end
        end
        lowc = 0;
        g    = 0;
        while (busy && g < 300) begin
            if (!s_ready) lowc++;
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < FLUSH_LEN; i++) exp_dp.push_back('0);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy: got %b want 0", busy);
        end
        n_checks++;
        if (lowc !== FLUSH_LEN) begin
            n_fail++;
            $display("FAIL single_flush_ready_low: got %0d cycles want %0d", lowc, FLUSH_LEN);
        end
        bad = 0;
        for (int i = 0; i < exp_dp.size() && i < dp_q.size(); i++)
            if (dp_q[i] !== exp_dp[i]) bad++;
        n_checks++;
        if (dp_q.size() !== exp_dp.size() || bad !== 0) begin
            n_fail++;
            $display("FAIL single_dp_stream: got %0d beats (%0d differ) want %0d beats",
                     dp_q.size(), bad, exp_dp.size());
        end
        bad = 0;
        for (int k = 0; k < m_q.size(); k++) if (m_q[k] !== exp_tag(k)) bad++;
        n_checks++;
        if (m_q.size() !== N || bad !== 0) begin
            n_fail++;
            $display("FAIL single_out_tags: got %0d beats (%0d wrong) want %0d", m_q.size(), bad, N);
        end
        n_checks++;
        if (err_cnt - e0 !== 0) begin
            n_fail++;
            $display("FAIL single_no_err: got %0d pulses want 0", err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*DATA_W-1:0] exp_dp[$];
        logic [DATA_W-1:0]   re;
        logic [DATA_W-1:0]   im;
        bit ok;
        bit all_ok;
        int bad;
        int nfirst;
        int nlast;
        dp_q.delete();
        m_q.delete();
        all_ok = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            re = DATA_W'($urandom);
            im = DATA_W'($urandom);
            send(re, im, (i % N) == N - 1, ok);
            all_ok &= ok;
            exp_dp.push_back({re, im});
        end
        for (int i = 0; i < FLUSH_LEN; i++) exp_dp.push_back('0);
        wait_idle(ok);
        n_checks++;
        if ({all_ok, ok} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_handshake: got accept_ok=%b idle_ok=%b want 1 1", all_ok, ok);
        end
        bad = 0;
        for (int i = 0; i < exp_dp.size() && i < dp_q.size(); i++)
            if (dp_q[i] !== exp_dp[i]) bad++;
        n_checks++;
        if (dp_q.size() !== exp_dp.size() || bad !== 0) begin
            n_fail++;
            $display("FAIL b2b_dp_stream: got %0d beats (%0d differ) want %0d beats",
                     dp_q.size(), bad, exp_dp.size());
        end
        bad    = 0;
        nfirst = 0;
        nlast  = 0;
        for (int k = 0; k < m_q.size(); k++) begin
            if (m_q[k] !== exp_tag(k)) bad++;
            if (m_q[k][FFT_STAGE+1] === 1'b1) nfirst++;
            if (m_q[k][FFT_STAGE] === 1'b1) nlast++;
        end
        n_checks++;
        if (m_q.size() !== 2 * N || bad !== 0) begin
            n_fail++;
            $display("FAIL b2b_out_tags: got %0d beats (%0d wrong) want %0d", m_q.size(), bad, 2 * N);
        end
        n_checks++;
        if (nfirst !== 2 || nlast !== 2) begin
            n_fail++;
            $display("FAIL b2b_first_last: got first=%0d last=%0d want 2 2", nfirst, nlast);
        end
    endtask

    task automatic test_short_frame();
        logic [2*DATA_W-1:0] exp_dp[$];
        logic [DATA_W-1:0]   re;
        logic [DATA_W-1:0]   im;
        bit ok;
        int bad;
        int e0;
        dp_q.delete();
        m_q.delete();
        e0 = err_cnt;
        for (int i = 0; i < 5; i++) begin
            re = DATA_W'($urandom);
            im = DATA_W'($urandom);
            send(re, im, i == 4, ok);
            exp_dp.push_back({re, im});
        end
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL short_err_pulse: got %b want 1", frame_err);
        end
        @(negedge clk);
        n_checks++;
        if ({frame_err, s_ready, dp_en} !== 3'b001) begin
            n_fail++;
            $display("FAIL short_pad_state: got err=%b ready=%b en=%b want 0 0 1",
                     frame_err, s_ready, dp_en);
        end
        for (int i = 5; i < N; i++) exp_dp.push_back('0);
        for (int i = 0; i < FLUSH_LEN; i++) exp_dp.push_back('0);
        wait_idle(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL short_idle: got busy=%b want 0", busy);
        end
        bad = 0;
        for (int i = 0; i < exp_dp.size() && i < dp_q.size(); i++)
            if (dp_q[i] !== exp_dp[i]) bad++;
        n_checks++;
        if (dp_q.size() !== exp_dp.size() || bad !== 0) begin
            n_fail++;
            $display("FAIL short_dp_stream: got %0d beats (%0d differ) want %0d beats",
                     dp_q.size(), bad, exp_dp.size());
        end
        bad = 0;
        for (int k = 0; k < m_q.size(); k++) if (m_q[k] !== exp_tag(k)) bad++;
        n_checks++;
        if (m_q.size() !== N || bad !== 0) begin
            n_fail++;
            $display("FAIL short_out_tags: got %0d beats (%0d wrong) want %0d", m_q.size(), bad, N);
        end
        n_checks++;
        if (err_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL short_err_count: got %0d pulses want 1", err_cnt - e0);
        end
    endtask

    task automatic test_gaps();
        logic [2*DATA_W-1:0] exp_dp[$];
        logic [DATA_W-1:0]   re;
        logic [DATA_W-1:0]   im;
        logic [DATA_W-1:0]   prev_re;
        bit ok;
        bit all_ok;
        int nfr;
        int nshort;
        int len;
        int bad;
        int e0;
        dp_q.delete();
        m_q.delete();
        e0      = err_cnt;
        all_ok  = 1'b1;
        nshort  = 0;
        nfr     = 4;
        prev_re = '0;
        for (int f = 0; f < nfr; f++) begin
            len = $urandom_range(N, 1);
            if (len < N) nshort++;
            for (int j = 0; j < len; j++) begin
                if (j > 0 && $urandom_range(1, 0) == 1) begin
                    @(negedge clk);
                    n_checks++;
                    if ({dp_en, dp_re, s_ready} !== {1'b0, prev_re, 1'b1}) begin
                        n_fail++;
                        $display("FAIL gap_hold f%0d s%0d: got en=%b re=%h ready=%b want 0 %h 1",
                                 f, j, dp_en, dp_re, s_ready, prev_re);
                    end
                end
                re = DATA_W'($urandom);
                im = DATA_W'($urandom);
                send(re, im, (j == len - 1) && (len < N || $urandom_range(1, 0) == 1), ok);
                all_ok &= ok;
                exp_dp.push_back({re, im});
                prev_re = re;
            end
            for (int j = len; j < N; j++) exp_dp.push_back('0);
        end
        for (int i = 0; i < FLUSH_LEN; i++) exp_dp.push_back('0);
        wait_idle(ok);
        n_checks++;
        if ({all_ok, ok} !== 2'b11) begin
            n_fail++;
            $display("FAIL gap_handshake: got accept_ok=%b idle_ok=%b want 1 1", all_ok, ok);
        end
        bad = 0;
        for (int i = 0; i < exp_dp.size() && i < dp_q.size(); i++)
            if (dp_q[i] !== exp_dp[i]) bad++;
        n_checks++;
        if (dp_q.size() !== exp_dp.size() || bad !== 0) begin
            n_fail++;
            $display("FAIL gap_dp_stream: got %0d beats (%0d differ) want %0d beats",
                     dp_q.size(), bad, exp_dp.size());
        end
        bad = 0;
        for (int k = 0; k < m_q.size(); k++) if (m_q[k] !== exp_tag(k)) bad++;
        n_checks++;
        if (m_q.size() !== N * nfr || bad !== 0) begin
            n_fail++;
            $display("FAIL gap_out_tags: got %0d beats (%0d wrong) want %0d", m_q.size(), bad, N * nfr);
        end
        n_checks++;
        if (err_cnt - e0 !== nshort) begin
            n_fail++;
            $display("FAIL gap_err_count: got %0d pulses want %0d", err_cnt - e0, nshort);
        end
    endtask

    task automatic test_idle_do_en();
        logic [DATA_W-1:0] re;
        bit ok;
        int bad;
        dp_q.delete();
        m_q.delete();
        extra_do = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_do_en_masked[%0d]: got m_valid=%b want 0", i, m_valid);
            end
        end
        extra_do = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_do_en_busy: got %b want 0", busy);
        end
        for (int i = 0; i < N; i++) begin
            re = DATA_W'($urandom);
            send(re, DATA_W'($urandom), i == N - 1, ok);
        end
        wait_idle(ok);
        bad = 0;
        for (int k = 0; k < m_q.size(); k++) if (m_q[k] !== exp_tag(k)) bad++;
        n_checks++;
        if (m_q.size() !== N || bad !== 0 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_do_en_out_held: got %0d beats (%0d wrong, idle=%b) want %0d",
                     m_q.size(), bad, ok, N);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int bad;
        for (int i = 0; i < 4; i++) send(DATA_W'($urandom), DATA_W'($urandom), 1'b0, ok);
        rstn = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, dp_en, s_ready, frame_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: got busy=%b en=%b ready=%b err=%b want 0 0 0 0",
                     busy, dp_en, s_ready, frame_err);
        end
        rstn = 1'b1;
        @(negedge clk);
        dp_q.delete();
        m_q.delete();
        for (int i = 0; i < N; i++) send(DATA_W'($urandom), DATA_W'($urandom), i == N - 1, ok);
        wait_idle(ok);
        bad = 0;
        for (int k = 0; k < m_q.size(); k++) if (m_q[k] !== exp_tag(k)) bad++;
        n_checks++;
        if (ok !== 1'b1 || dp_q.size() !== N + FLUSH_LEN || m_q.size() !== N || bad !== 0) begin
            n_fail++;
            $display("FAIL midreset_next_frame: got idle=%b dp=%0d m=%0d (%0d wrong) want 1 %0d %0d",
                     ok, dp_q.size(), m_q.size(), bad, N + FLUSH_LEN, N);
        end
    endtask

    initial begin
        rstn    = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_re    = '0;
        s_im    = '0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_short_frame();
        test_gaps();
        test_idle_do_en();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
